ex_wb_pipeline_regs: RTL and testbench
======================================

Name: ex_wb_pipeline_regs

Overview:
- Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage RV32I core.
- Produces the rd / reg-write-enable / result signals that the forwarding logic consumes.
- Drives the data-memory request and performs load extraction / sign extension.
- Sits between the ALU (EX) and the register-file write port (WB); owns stall, flush and bubble insertion for the back half of the pipe.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_stall  in  1  data memory not ready; hold both stages
- flush_ex_mem  in  1  turn the instruction entering EX/MEM into a bubble
- ex_valid  in  1  EX holds a real instruction
- ex_rd  in  5  destination register
- ex_reg_write_en  in  1  instruction writes rd
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  load/store size code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ex_alu_result  in  XLEN  ALU result / effective address
- ex_store_data  in  XLEN  rs2 value for stores
- dmem_rdata  in  XLEN  memory read data, valid in the cycle the load is in EX/MEM and mem_stall=0
- dmem_addr  out  XLEN  word-aligned address ({ex_mem_alu_result[31:2],2'b00})
- dmem_read  out  1  load request
- dmem_write  out  1  store request
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  XLEN  lane-shifted store data
- ex_mem_rd_out  out  5  rd in EX/MEM
- ex_mem_reg_write_en_out  out  1  EX/MEM writes rd (0 for bubble)
- ex_mem_is_load  out  1  EX/MEM holds a load; its forwardable value is not yet data
- ex_mem_alu_result  out  XLEN  forward value from MEM stage
- mem_wb_rd_out  out  5  rd in MEM/WB
- mem_wb_reg_write_en_out  out  1  register-file write enable
- mem_wb_wdata  out  XLEN  write-back / forward value from WB stage
- retired_count  out  CNT_W  count of instructions leaving WB

Behaviour:
- Reset (rst_n=0, asynchronous): all registered outputs are 0 and both stages hold bubbles; retired_count=0.
- Combinational outputs derived from a bubble:
  - dmem_read=0, dmem_write=0, dmem_wstrb=0.
  - dmem_addr and dmem_wdata follow the zeroed registers.
- Release of reset is synchronous to clk; the first capture happens on the first rising edge after release.
- Normal advance (mem_stall=0), latency 1 cycle per stage:
  - EX/MEM <= EX inputs.
  - MEM/WB <= {rd, reg_write_en, result}.
- A bubble is any stage with valid=0; it forces reg_write_en, mem_read and mem_write to 0 regardless of the captured inputs.
- Loads write back extracted dmem_rdata; non-loads write back ex_mem_alu_result.
- Load extraction: off = addr[1:0].
  - B/BU: byte lane off, sign- or zero-extended.
  - H/HU: half lane addr[1]; addr[0] ignored.
  - W: addr[1:0] ignored.
  - Undefined funct3: write back 0.
- Store lanes:
  - SB: wstrb = 0001<<off, data byte replicated to all 4 lanes.
  - SH: wstrb = 0011<<(2*addr[1]), halfword replicated to both halves.
  - SW: wstrb = 1111.
- mem_stall=1: both EX/MEM and MEM/WB hold every field, and retired_count does not increment.
  - dmem_* outputs stay asserted so the request is held stable until accepted.
  - mem_wb_reg_write_en_out stays asserted; the repeated write of the same value is harmless and keeps the forward value stable for a stalled EX.
- flush_ex_mem=1: EX/MEM captures a bubble on the next edge. Flush has priority over mem_stall for EX/MEM only; MEM/WB still obeys mem_stall.
- rd = 0: captured as given; ex_mem_reg_write_en_out / mem_wb_reg_write_en_out are forced to 0 when rd = 0.
- retired_count increments by 1 on every edge with mem_stall=0 where MEM/WB holds a valid instruction. Wraps modulo 2^CNT_W.
- Reset asserted mid-stall: all state clears immediately and any in-flight memory request is dropped.

Test Plan:
- Reset then ADD x5 (alu 0x0000_00AA): cycle+1 ex_mem_rd_out=5, en=1, alu=0xAA; cycle+2 mem_wb_rd_out=5, wdata=0xAA, en=1; retired_count=1 after cycle+3 edge.
- LB x7 at addr 0x1003 with dmem_rdata=0x80FF_1234: dmem_addr=0x1000, dmem_read=1, ex_mem_is_load=1; next cycle mem_wb_wdata=0xFFFF_FF80. LBU at the same address gives 0x0000_0080. LH at 0x1002 gives 0xFFFF_80FF.
- SB data 0x0000_00CD at addr 0x2001: dmem_write=1, dmem_wstrb=0010, dmem_wdata=0xCDCD_CDCD, mem_wb_reg_write_en_out=0.
- mem_stall held 3 cycles during an LW: all outputs constant for 3 cycles, retired_count unchanged; release gives normal advance on the next edge.
- flush_ex_mem together with mem_stall, then ADDI x0 (rd = 0): flushed slot shows en=0, dmem_read=0; the x0 instruction never asserts either write enable but still increments retired_count.
- rst_n pulsed low mid-cycle during a store: dmem_write and all registers are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_wb_pipeline_regs.sv
// Back half of the RV32I pipe: EX/MEM and MEM/WB registers, data-memory request
// generation, load extraction and the retired-instruction counter.
module ex_wb_pipeline_regs #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_stall,
  input  logic             flush_ex_mem,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write_en,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [XLEN-1:0]  dmem_addr,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [3:0]       dmem_wstrb,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [4:0]       ex_mem_rd_out,
  output logic             ex_mem_reg_write_en_out,
  output logic             ex_mem_is_load,
  output logic [XLEN-1:0]  ex_mem_alu_result,
  output logic [4:0]       mem_wb_rd_out,
  output logic             mem_wb_reg_write_en_out,
  output logic [XLEN-1:0]  mem_wb_wdata,
  output logic [CNT_W-1:0] retired_count
);
  localparam int NUM_LANES = XLEN / 8;

  typedef struct packed {
    logic [4:0]      rd;
    logic            we;
    logic            ld;
    logic            st;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;
  } mem_wb_t;

  ex_mem_t                      em_d, em_q;
  mem_wb_t                      mw_d, mw_q;
  logic [1:0]                   vld_pipe_d, vld_pipe_q;  // [0] EX/MEM, [1] MEM/WB
  logic [CNT_W-1:0]             retired_d, retired_q;
  logic                         ex_live;
  logic [NUM_LANES-1:0][7:0]    rdata_lanes;
  logic [NUM_LANES-1:0][7:0]    wdata_lanes;
  logic [NUM_LANES-1:0]         wstrb;
  logic [7:0]                   ld_byte;
  logic [15:0]                  ld_half;
  logic [XLEN-1:0]              ld_data;

  assign rdata_lanes = dmem_rdata;

  always_comb begin
    ld_byte = rdata_lanes[em_q.alu[1:0]];
    ld_half = em_q.alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = '0;
    case (em_q.funct3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b010:  ld_data = dmem_rdata;
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ex_wb_store_lane #(.LANE(i)) u_lane (
      .mem_write (em_q.st),
      .funct3    (em_q.funct3),
      .off       (em_q.alu[1:0]),
      .b_byte    (em_q.sdata[7:0]),
      .h_byte    (em_q.sdata[8*(i%2) +: 8]),
      .w_byte    (em_q.sdata[8*i +: 8]),
      .strb      (wstrb[i]),
      .wbyte     (wdata_lanes[i])
    );
  end

  always_comb begin
    em_d       = em_q;
    mw_d       = mw_q;
    vld_pipe_d = vld_pipe_q;
    retired_d  = retired_q;
    ex_live    = ex_valid & ~flush_ex_mem;
    // Flush overrides the stall for EX/MEM only: the slot is bubbled even while held.
    if (flush_ex_mem || !mem_stall) begin
      vld_pipe_d[0] = ex_live;
      em_d.rd       = ex_rd;
      em_d.we       = ex_live & ex_reg_write_en & (ex_rd != 5'd0);
      em_d.ld       = ex_live & ex_mem_read;
      em_d.st       = ex_live & ex_mem_write;
      em_d.funct3   = ex_funct3;
      em_d.alu      = ex_alu_result;
      em_d.sdata    = ex_store_data;
    end
    if (!mem_stall) begin
      vld_pipe_d[1] = vld_pipe_q[0];
      mw_d.rd       = em_q.rd;
      mw_d.we       = em_q.we;
      mw_d.wdata    = em_q.ld ? ld_data : em_q.alu;
      if (vld_pipe_q[1]) retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_q       <= '0;
      mw_q       <= '0;
      vld_pipe_q <= '0;
      retired_q  <= '0;
    end else begin
      em_q       <= em_d;
      mw_q       <= mw_d;
      vld_pipe_q <= vld_pipe_d;
      retired_q  <= retired_d;
    end
  end

  assign dmem_addr               = {em_q.alu[XLEN-1:2], 2'b00};
  assign dmem_read               = em_q.ld;
  assign dmem_write              = em_q.st;
  assign dmem_wstrb              = wstrb;
  assign dmem_wdata              = wdata_lanes;
  assign ex_mem_rd_out           = em_q.rd;
  assign ex_mem_reg_write_en_out = em_q.we;
  assign ex_mem_is_load          = em_q.ld;
  assign ex_mem_alu_result       = em_q.alu;
  assign mem_wb_rd_out           = mw_q.rd;
  assign mem_wb_reg_write_en_out = mw_q.we;
  assign mem_wb_wdata            = mw_q.wdata;
  assign retired_count           = retired_q;
endmodule

// One byte lane of the store path: strobe and lane data for SB/SH/SW.
module ex_wb_store_lane #(
  parameter int LANE = 0
) (
  input  logic       mem_write,
  input  logic [2:0] funct3,
  input  logic [1:0] off,
  input  logic [7:0] b_byte,
  input  logic [7:0] h_byte,
  input  logic [7:0] w_byte,
  output logic       strb,
  output logic [7:0] wbyte
);
  localparam logic [1:0] LIDX = LANE[1:0];

  always_comb begin
    strb  = 1'b0;
    wbyte = w_byte;
    case (funct3)
      3'b000: begin
        strb  = mem_write & (off == LIDX);
        wbyte = b_byte;
      end
      3'b001: begin
        strb  = mem_write & (off[1] == LIDX[1]);
        wbyte = h_byte;
      end
      3'b010:  strb = mem_write;
      default: strb = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_ex_wb_pipeline_regs.sv
// Directed and random checks of ex_wb_pipeline_regs against an instruction-level model.
module tb_ex_wb_pipeline_regs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_stall = 1'b0, flush_ex_mem = 1'b0;
  logic        ex_valid = 1'b0, ex_reg_write_en = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_alu_result = '0, ex_store_data = '0, dmem_rdata = '0;
  logic [31:0] dmem_addr, dmem_wdata, ex_mem_alu_result, mem_wb_wdata, retired_count;
  logic        dmem_read, dmem_write, ex_mem_reg_write_en_out, ex_mem_is_load, mem_wb_reg_write_en_out;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  ex_mem_rd_out, mem_wb_rd_out;

  ex_wb_pipeline_regs #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .flush_ex_mem(flush_ex_mem),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write_en(ex_reg_write_en),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .dmem_rdata(dmem_rdata),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .ex_mem_rd_out(ex_mem_rd_out),
    .ex_mem_reg_write_en_out(ex_mem_reg_write_en_out), .ex_mem_is_load(ex_mem_is_load),
    .ex_mem_alu_result(ex_mem_alu_result), .mem_wb_rd_out(mem_wb_rd_out),
    .mem_wb_reg_write_en_out(mem_wb_reg_write_en_out), .mem_wb_wdata(mem_wb_wdata),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  typedef struct {
    bit v; bit [4:0] rd; bit we; bit ld; bit st; bit [2:0] f3; bit [31:0] a; bit [31:0] sd;
  } ins_t;

  ins_t        m_em, m_mw;
  bit   [31:0] m_res;
  int unsigned m_ret;

  function automatic bit eff_we(ins_t i);
    return i.v && i.we && (i.rd != 5'd0);
  endfunction

  function automatic bit [31:0] load_val(bit [2:0] f3, bit [31:0] a, bit [31:0] d);
    bit [31:0] b, h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd5:    return h;
      3'd2:    return d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit [3:0] strb_of(bit [2:0] f3, bit [31:0] a);
    case (f3)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return 4'b0011 << (2 * a[1]);
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit [31:0] wdata_of(bit [2:0] f3, bit [31:0] sd);
    case (f3)
      3'd0:    return (sd & 32'hFF) * 32'h0101_0101;
      3'd1:    return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  task automatic model_reset();
    m_em = '{default: 0};
    m_mw = '{default: 0};
    m_res = 0;
    m_ret = 0;
  endtask

  task automatic model_edge();
    ins_t in;
    in = '{ex_valid, ex_rd, ex_reg_write_en, ex_mem_read, ex_mem_write, ex_funct3,
           ex_alu_result, ex_store_data};
    if (!mem_stall) begin
      if (m_mw.v) m_ret++;
      m_mw  = m_em;
      m_res = (m_em.v && m_em.ld) ? load_val(m_em.f3, m_em.a, dmem_rdata) : m_em.a;
    end
    if (flush_ex_mem) begin
      m_em = in;
      m_em.v = 0;
    end else if (!mem_stall) begin
      m_em = in;
    end
  endtask

  task automatic check_all();
    bit st;
    st = m_em.v && m_em.st;
    chk("dmem_addr", dmem_addr, m_em.a & 32'hFFFF_FFFC);
    chk("dmem_read", dmem_read, m_em.v && m_em.ld);
    chk("dmem_write", dmem_write, st);
    chk("dmem_wstrb", dmem_wstrb, st ? strb_of(m_em.f3, m_em.a) : 4'b0);
    if (st) chk("dmem_wdata", dmem_wdata, wdata_of(m_em.f3, m_em.sd));
    chk("em_rd", ex_mem_rd_out, m_em.rd);
    chk("em_en", ex_mem_reg_write_en_out, eff_we(m_em));
    chk("em_is_load", ex_mem_is_load, m_em.v && m_em.ld);
    chk("em_alu", ex_mem_alu_result, m_em.a);
    chk("mw_rd", mem_wb_rd_out, m_mw.rd);
    chk("mw_en", mem_wb_reg_write_en_out, eff_we(m_mw));
    chk("mw_wdata", mem_wb_wdata, m_res);
    chk("retired", retired_count, m_ret);
  endtask

  task automatic drive(bit v, bit [4:0] rd, bit we, bit ld, bit st, bit [2:0] f3,
                       bit [31:0] a, bit [31:0] sd);
    ex_valid = v; ex_rd = rd; ex_reg_write_en = we; ex_mem_read = ld; ex_mem_write = st;
    ex_funct3 = f3; ex_alu_result = a; ex_store_data = sd;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  bit [2:0]  ld_f3  [3] = '{3'd0, 3'd4, 3'd1};
  bit [31:0] ld_adr [3] = '{32'h1003, 32'h1003, 32'h1002};
  bit [31:0] ld_exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};

  initial begin
    logic [31:0] snap_addr, snap_ret;
    int unsigned kind;
    bit [2:0]    f3;

    model_reset();
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // ADD x5
    drive(1, 5, 1, 0, 0, 0, 32'hAA, 0);
    cycle();
    chk("add_em_rd", ex_mem_rd_out, 5);
    chk("add_em_alu", ex_mem_alu_result, 32'hAA);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("add_mw_wdata", mem_wb_wdata, 32'hAA);
    chk("add_mw_en", mem_wb_reg_write_en_out, 1);
    cycle();
    chk("add_retired", retired_count, 1);

    // LB / LBU / LH extraction
    for (int i = 0; i < 3; i++) begin
      drive(1, 7, 1, 1, 0, ld_f3[i], ld_adr[i], 0);
      cycle();
      chk("ld_addr", dmem_addr, ld_adr[i] & 32'hFFFF_FFFC);
      chk("ld_is_load", ex_mem_is_load, 1);
      dmem_rdata = 32'h80FF_1234;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("ld_wdata", mem_wb_wdata, ld_exp[i]);
    end

    // SB
    drive(1, 9, 0, 0, 1, 0, 32'h2001, 32'hCD);
    cycle();
    chk("sb_wstrb", dmem_wstrb, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'hCDCD_CDCD);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("sb_mw_en", mem_wb_reg_write_en_out, 0);

    // LW held by a 3-cycle stall
    drive(1, 3, 1, 1, 0, 2, 32'h3004, 0);
    cycle();
    snap_addr = 32'h3004;
    snap_ret  = m_ret;
    mem_stall = 1'b1;
    drive(1, 8, 1, 0, 0, 0, 32'h11, 0);
    for (int i = 0; i < 3; i++) begin
      dmem_rdata = $urandom;
      cycle();
      chk("stall_addr", dmem_addr, snap_addr);
      chk("stall_read", dmem_read, 1);
      chk("stall_ret", retired_count, snap_ret);
    end
    mem_stall  = 1'b0;
    dmem_rdata = 32'hDEAD_BEEF;
    cycle();
    chk("stall_rel_wdata", mem_wb_wdata, 32'hDEAD_BEEF);
    chk("stall_rel_em_rd", ex_mem_rd_out, 8);

    // Flush under stall, then ADDI x0
    drive(1, 6, 1, 1, 0, 2, 32'h55, 0);
    mem_stall = 1'b1; flush_ex_mem = 1'b1;
    cycle();
    chk("flush_en", ex_mem_reg_write_en_out, 0);
    chk("flush_read", dmem_read, 0);
    mem_stall = 1'b0; flush_ex_mem = 1'b0;
    drive(1, 0, 1, 0, 0, 0, 32'h77, 0);
    cycle();
    chk("x0_em_en", ex_mem_reg_write_en_out, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    snap_ret = m_ret;
    cycle();
    chk("x0_mw_en", mem_wb_reg_write_en_out, 0);
    cycle();
    chk("x0_retired", retired_count, snap_ret + 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 1) begin
        f3 = 3'($urandom_range(0, 7));
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      drive($urandom_range(0, 9) != 0, 5'($urandom), kind == 0 ? bit'($urandom) : kind == 1,
            kind == 1, kind == 2, f3, $urandom, $urandom);
      mem_stall    = $urandom_range(0, 4) == 0;
      flush_ex_mem = $urandom_range(0, 9) == 0;
      dmem_rdata   = $urandom;
      cycle();
    end
    mem_stall = 1'b0; flush_ex_mem = 1'b0;

    // Async reset mid-cycle during a stalled store
    drive(1, 0, 0, 0, 1, 2, 32'h40, 32'h1234_5678);
    cycle();
    chk("ar_write_pre", dmem_write, 1);
    mem_stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_write", dmem_write, 0);
    chk("ar_wstrb", dmem_wstrb, 0);
    chk("ar_retired", retired_count, 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1; mem_stall = 1'b0;
    drive(1, 2, 1, 0, 0, 0, 32'h99, 0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
